// File: rtl/i2s_codec_responder_pkg.sv
// -----------------------------------------------------------------------------
// i2s_codec_responder_pkg
//   Shared definitions for the I2S codec responder.
//   - state_t             : slot-tracking FSM state (SYNC, LEFT, RIGHT)
//   - DEFAULT_DATA_W      : default significant bits per channel word
//   - DEFAULT_SYNC_STAGES : default synchronizer depth for SCLK/LRCLK/SD_in
// -----------------------------------------------------------------------------
package i2s_codec_responder_pkg;

  localparam int DEFAULT_DATA_W      = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;

  // SYNC : waiting for the first LRCLK falling edge, transmitter silent
  // LEFT : inside the left slot (LRCLK low)
  // RIGHT: inside the right slot (LRCLK high)
  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
//   Brings one asynchronous level into the clk domain through SYNC_STAGES
//   flops, then registers the synchronized level once more so that single-
//   cycle rise/fall strobes can be formed.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset (clears every flop)
//   din   in  asynchronous input level
//   rise  out one-clk strobe: synchronized level went 0 -> 1
//   fall  out one-clk strobe: synchronized level went 1 -> 0
// -----------------------------------------------------------------------------
module sync_edge_det
  import i2s_codec_responder_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= level;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2s_codec_responder.sv
// -----------------------------------------------------------------------------
// i2s_codec_responder
//   I2S responder (codec side): the master supplies SCLK and LRCLK. Receives
//   a left/right DAC word pair on SD_in and transmits a left/right ADC word
//   pair on SD_out, both MSB first with the standard one-bit I2S delay.
//   All I2S pins are oversampled by clk (clk >= 8x SCLK).
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   SCLK      in   serial bit clock from the master (asynchronous)
//   LRCLK     in   word select, low = left slot, high = right slot
//   SD_in     in   serial data from the master, valid on SCLK rise
//   SD_out    out  serial data to the master, updated after SCLK fall
//   tx_left   in   left sample to transmit, captured at frame start
//   tx_right  in   right sample to transmit, captured at frame start
//   tx_req    out  one-clk pulse in the cycle tx_left/tx_right are captured
//   rx_left   out  left word of the last complete received frame
//   rx_right  out  right word of the last complete received frame
//   rx_valid  out  one-clk pulse: rx_left/rx_right just updated
//   frame_err out  one-clk pulse: LRCLK edge ended a slot that was too short
//   dbg_state out  current FSM state
// Handshake: tx_req, rx_valid and frame_err are single-cycle strobes with no
//   back-pressure; the consumer must act on them in the cycle they are high.
// -----------------------------------------------------------------------------
module i2s_codec_responder
  import i2s_codec_responder_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              LRCLK,
  input  logic              SD_in,
  output logic              SD_out,
  input  logic [DATA_W-1:0] tx_left,
  input  logic [DATA_W-1:0] tx_right,
  output logic              tx_req,
  output logic [DATA_W-1:0] rx_left,
  output logic [DATA_W-1:0] rx_right,
  output logic              rx_valid,
  output logic              frame_err,
  output state_t            dbg_state
);

  // Slot counter counts SCLK rises since the last LRCLK edge and saturates
  // at DATA_W+1 (delay bit plus DATA_W data bits = a complete slot).
  localparam int              CNT_W    = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------------------
  logic sclk_rise, sclk_fall;
  logic lr_rise, lr_fall, lr_edge;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_det (
    .clk  (clk),
    .rst  (rst),
    .din  (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_lrclk_det (
    .clk  (clk),
    .rst  (rst),
    .din  (LRCLK),
    .rise (lr_rise),
    .fall (lr_fall)
  );

  // SD_in goes through the same depth as the last sync stage of SCLK, so the
  // synchronized data bit lines up with the cycle sclk_rise is reported.
  logic [SYNC_STAGES-1:0] sd_sync_q;
  logic                   sd_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sd_sync_q <= '0;
    end else begin
      sd_sync_q[0] <= SD_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sd_sync_q[i] <= sd_sync_q[i-1];
      end
    end
  end

  assign sd_sync = sd_sync_q[SYNC_STAGES-1];
  assign lr_edge = lr_rise | lr_fall;

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / output decode
  // ---------------------------------------------------------------------------
  state_t state, state_next;
  logic   in_slot, in_right;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SYNC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SYNC:    if (lr_fall) state_next = LEFT;
      LEFT:    if (lr_rise) state_next = RIGHT;
      RIGHT:   if (lr_fall) state_next = LEFT;
      default: state_next = SYNC;
    endcase
  end

  always_comb begin
    in_slot  = 1'b0;
    in_right = 1'b0;
    case (state)
      LEFT:    in_slot = 1'b1;
      RIGHT: begin
        in_slot  = 1'b1;
        in_right = 1'b1;
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Slot bookkeeping
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] slot_cnt;
  logic             slot_short;
  logic             sample_bit;
  logic             word_done;
  logic             drive_bit;

  assign slot_short = (slot_cnt != CNT_MAX);

  // Rise 0 carries the previous word's delay bit; rises 1..DATA_W carry data.
  assign sample_bit = sclk_rise & in_slot & ~lr_edge
                    & (slot_cnt != CNT_ZERO) & (slot_cnt <= CNT_LAST);
  assign word_done  = sample_bit & (slot_cnt == CNT_LAST);

  // At the k-th fall after the LRCLK edge the counter already holds k, so
  // falls 1..DATA_W shift data out and later falls drive the idle zero.
  assign drive_bit  = (slot_cnt != CNT_ZERO) & (slot_cnt <= CNT_LAST);

  assign tx_req    = lr_fall;
  assign frame_err = in_slot & lr_edge & slot_short;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
    end else if (lr_edge) begin
      slot_cnt <= '0;
    end else if (sclk_rise && slot_cnt != CNT_MAX) begin
      slot_cnt <= slot_cnt + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit path
  // ---------------------------------------------------------------------------
  // The left word goes straight into the shift register at frame start; only
  // the right word needs a separate holding register so that later changes
  // of tx_right do not leak into the frame already in flight.
  logic [DATA_W-1:0] tx_hold_right;
  logic [DATA_W-1:0] tx_shift;
  logic              sd_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_hold_right <= '0;
      tx_shift      <= '0;
      sd_out_q      <= 1'b0;
    end else begin
      if (lr_fall) begin
        tx_hold_right <= tx_right;
        tx_shift      <= tx_left;
      end else if (lr_rise) begin
        tx_shift <= tx_hold_right;
      end else if (sclk_fall && in_slot) begin
        if (drive_bit) begin
          sd_out_q <= tx_shift[DATA_W-1];
          tx_shift <= tx_shift << 1;
        end else begin
          sd_out_q <= 1'b0;
        end
      end
      // An LRCLK edge coincides with the master's fall for the delay bit:
      // SD_out keeps the previous word's last bit through that fall.
      if (!in_slot) begin
        sd_out_q <= 1'b0;
      end
    end
  end

  assign SD_out = sd_out_q;

  // ---------------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------------
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-1:0] left_word;
  logic              left_ok;
  logic [DATA_W-1:0] rx_left_q, rx_right_q;
  logic              rx_valid_q;

  assign rx_word = {rx_shift, sd_sync};

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift   <= '0;
      left_word  <= '0;
      left_ok    <= 1'b0;
      rx_left_q  <= '0;
      rx_right_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      // A frame is only published if its left slot ran to full length.
      if (lr_fall) begin
        left_ok <= 1'b0;
      end else if (lr_rise) begin
        left_ok <= in_slot & ~in_right & ~slot_short;
      end
      if (sample_bit) begin
        rx_shift <= rx_word[DATA_W-2:0];
      end
      if (word_done && !in_right) begin
        left_word <= rx_word;
      end
      if (word_done && in_right && left_ok) begin
        rx_left_q  <= left_word;
        rx_right_q <= rx_word;
        rx_valid_q <= 1'b1;
      end
    end
  end

  assign rx_left  = rx_left_q;
  assign rx_right = rx_right_q;
  assign rx_valid = rx_valid_q;

endmodule
